// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit for the execute stage.
//                It covers all eight M-extension ops. Multiply is radix-2
//                shift-add and divide is restoring shift-subtract, each on
//                operand magnitudes. Signs are applied in a final FIX cycle.
//                Divide-by-zero and signed overflow are resolved at accept
//                and complete with a latency of 1.
//  Optional    : `define MULDIV_FAST_MUL_EN gives multiplies a single-cycle
//                combinational product, so multiply latency becomes 2.
//                Without it, no hardware multiplier is inferred.
//  Ports       : clk    in   rising-edge clock
//                reset  in   asynchronous active-low reset
//                start  in   request, accepted when start && ready
//                op     in   func3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//                a, b   in   rs1 / rs2 operands, sampled at accept
//                flush  in   synchronous abort of the in-flight op
//                ready  out  idle, can accept start
//                busy   out  op in flight (CALC/FIX)
//                done   out  one-cycle pulse, result valid
//                result out  registered result, held until the next accept
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     opa_q, opa_d;     // |a|: multiplicand, or dividend shifted out MSB-first
  logic [XLEN-1:0]     opb_q, opb_d;     // |b|: multiplier shifted out LSB-first, or divisor
  logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {partial hi, product lo}; div: {remainder, quotient}
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;     // final result must be negated
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  // --------------------------------------------------------------------------
  // Accept-time decode: signedness, magnitudes, sign flag, special cases
  // --------------------------------------------------------------------------
  logic            w_a_signed, w_b_signed;
  logic            w_sa, w_sb;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic            w_neg;
  logic            w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_special_res;

  assign w_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign w_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign w_sa       = w_a_signed & a[XLEN-1];
  assign w_sb       = w_b_signed & b[XLEN-1];
  // -MIN wraps to MIN, which is still the correct unsigned magnitude.
  assign w_abs_a    = w_sa ? -a : a;
  assign w_abs_b    = w_sb ? -b : b;
  // Remainder follows the dividend's sign; everything else is sign(a)^sign(b).
  assign w_neg      = (op[2] && op[1]) ? w_sa : (w_sa ^ w_sb);

  assign w_b_zero   = (b == '0);
  assign w_ovf      = (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b) && !op[0];
  assign w_special  = op[2] && (w_b_zero || w_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_b_zero) begin
      w_special_res = op[1] ? a : '1;
    end else begin
      w_special_res = op[1] ? '0 : a;
    end
  end

  // --------------------------------------------------------------------------
  // One radix-2 step of each algorithm
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]   w_mul_add;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_acc;

  // Add the multiplicand into the high half when the multiplier LSB is set,
  // then shift the whole accumulator right, carry included.
  assign w_mul_add = opb_q[0] ? opa_q : '0;
  assign w_mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, w_mul_add};
  assign w_mul_acc = {w_mul_sum, acc_q[XLEN-1:1]};

  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_div_acc;

  // Bring the next dividend bit into the partial remainder and trial-subtract.
  // The shifted remainder is below 2*|b|, so bit XLEN of the difference is
  // the borrow.
  assign w_rem_sh  = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, opb_q};
  assign w_qbit    = ~w_diff[XLEN];
  assign w_div_acc = {(w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                      acc_q[XLEN-2:0], w_qbit};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  // Magnitude product. The sign is restored by the same selection used in
  // FIX, which is equivalent to a product of sign-extended operands.
  assign w_fast_prod = {{XLEN{1'b0}}, opa_q} * {{XLEN{1'b0}}, opb_q};
`endif

  // Apply the sign and pick the architecturally visible part of the result.
  function automatic logic [XLEN-1:0] fix_select(
    input logic [2:0]        f_op,
    input logic              f_neg,
    input logic [2*XLEN-1:0] f_acc
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   sel;
    prod = f_neg ? -f_acc : f_acc;
    sel  = f_op[1] ? f_acc[2*XLEN-1:XLEN] : f_acc[XLEN-1:0];
    if (f_op[2]) begin
      fix_select = f_neg ? -sel : sel;
    end else if (f_op[1:0] == 2'b00) begin
      fix_select = prod[XLEN-1:0];
    end else begin
      fix_select = prod[2*XLEN-1:XLEN];
    end
  endfunction

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A flush in the same cycle drops the request.
        if (start && !flush) begin
          op_d  = op;
          opa_d = w_abs_a;
          opb_d = w_abs_b;
          neg_d = w_neg;
          acc_d = '0;
          cnt_d = '0;
          if (w_special) begin
            result_d = w_special_res;
            done_d   = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!op_q[2]) begin
          // Single-cycle multiply: the sign fix and selection happen here too,
          // so the result arrives two cycles after accept.
          acc_d    = w_fast_prod;
          result_d = fix_select(op_q, neg_q, w_fast_prod);
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
`endif
        else begin
          if (op_q[2]) begin
            acc_d = w_div_acc;
            opa_d = opa_q << 1;
          end else begin
            acc_d = w_mul_acc;
            opb_d = opb_q >> 1;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          result_d = fix_select(op_q, neg_q, acc_q);
          done_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit. A vector table drives
//                back-to-back ops. Each issue pushes its expected result and
//                latency onto a scoreboard, which is popped when done pulses.
//                Hand-written sequences cover reset, flush and async reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif
  localparam int DIV_LAT = XLEN + 2;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      op    = '0;
  logic [XLEN-1:0] a     = '0;
  logic [XLEN-1:0] b     = '0;
  logic            ready, busy, done;
  logic [XLEN-1:0] result;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Index of the current cycle (the interval following posedge number cyc).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] exp;
    int              acc;
    int              lat;
    int              id;
  } sb_t;

  vec_t vq[$];
  sb_t  sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   next_id = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                     input logic [XLEN-1:0] e, input int l);
    vq.push_back('{op: o, a: x, b: y, exp: e, lat: l});
  endtask

  // Pops one scoreboard entry per done pulse; a pulse with nothing expected is an error.
  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("result[%0d]", e.id), result, e.exp);
          chk($sformatf("latency[%0d]", e.id), XLEN'(cyc - e.acc), XLEN'(e.lat));
        end
      end
    end
  endtask

  // Called at a negedge; returns at a negedge with ready high (or after a bounded wait).
  task automatic wait_ready();
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got ready=%b, expected 1 within 200 cycles", ready);
    end
  endtask

  // Drive one request for a single cycle; optionally register its expectation.
  task automatic launch(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        input bit expect_done, input logic [XLEN-1:0] e, input int l);
    wait_ready();
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (expect_done) begin
      sbq.push_back('{exp: e, acc: cyc, lat: l, id: next_id});
      next_id++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got %0d ops outstanding, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [XLEN-1:0] last_exp;

  initial begin
    // Architectural results, worked out from the RV32M definitions.
    add(MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    add(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    add(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    add(MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_LAT);
    add(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    add(MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, MUL_LAT);
    add(MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    add(DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT);
    add(REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT);
    add(DIVU,   32'd100,      32'd7,        32'd14,        DIV_LAT);
    add(REMU,   32'd100,      32'd7,        32'd2,         DIV_LAT);
    add(DIV,    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,        DIV_LAT);
    add(REM,    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, DIV_LAT);
    add(DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
    add(REM,    32'd7,        32'hFFFF_FFFE, 32'd1,         DIV_LAT);
    add(DIVU,   32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, DIV_LAT);
    add(REMU,   32'hFFFF_FFFF, 32'd10,       32'd5,         DIV_LAT);
    add(DIV,    32'h8000_0000, 32'd1,        32'h8000_0000, DIV_LAT);
    add(DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    add(REM,    32'd5,        32'd0,        32'd5,         1);
    add(DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    add(REMU,   32'd5,        32'd0,        32'd5,         1);
    add(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    add(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    add(MUL,    32'd3,        32'd4,        32'd12,        MUL_LAT);

    // Reset state.
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_done",   XLEN'(done),  '0);
    chk("rst_busy",   XLEN'(busy),  '0);
    chk("rst_result", result,       '0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready",  XLEN'(ready), XLEN'(1));

    fork
      monitor();
    join_none

    // Back-to-back table: each start is raised in the previous done cycle.
    for (int i = 0; i < vq.size(); i++) begin
      launch(vq[i].op, vq[i].a, vq[i].b, 1'b1, vq[i].exp, vq[i].lat);
    end
    drain();

    // busy/ready while a multiply is in flight.
    launch(MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, MUL_LAT);
    chk("mul_busy",  XLEN'(busy),  XLEN'(1));
    chk("mul_ready", XLEN'(ready), '0);
    drain();
    last_exp = 32'hFFFF_FFEB;

    // Flush 10 cycles after accepting DIV 1000/3: no done, result unchanged.
    launch(DIV, 32'd1000, 32'd3, 1'b0, '0, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready",  XLEN'(ready), XLEN'(1));
    chk("flush_busy",   XLEN'(busy),  '0);
    chk("flush_result", result,       last_exp);
    repeat (40) @(negedge clk);
    chk("flush_hold",   result,       last_exp);

    launch(MUL, 32'd3, 32'd4, 1'b1, 32'd12, MUL_LAT);
    drain();

    // Flush and start together: the start is dropped.
    wait_ready();
    op    = DIVU;
    a     = 32'd9;
    b     = 32'd0;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("fs_busy",   XLEN'(busy),  '0);
    chk("fs_ready",  XLEN'(ready), XLEN'(1));
    repeat (40) @(negedge clk);
    chk("fs_result", result,       32'd12);

    // Asynchronous reset in the middle of a DIVU.
    launch(DIVU, 32'd1000, 32'd7, 1'b0, '0, 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_done",   XLEN'(done), '0);
    chk("arst_busy",   XLEN'(busy), '0);
    chk("arst_result", result,      '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("arst_ready",  XLEN'(ready), XLEN'(1));
    launch(REMU, 32'd17, 32'd5, 1'b1, 32'd2, DIV_LAT);
    drain();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
